// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: issues one data-memory access per instruction, stalls upstream
// until the memory answers or a timeout expires, then registers the writeback payload.
module mem_wb_stage #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_incPC,
    input  logic [15:0] in_aluResult,
    input  logic [15:0] in_writeData,
    input  logic [15:0] in_inst7_0Ext,
    input  logic [15:0] in_aluControl,
    input  logic [2:0]  in_writeBackOp,
    input  logic [2:0]  in_writeReg,
    input  logic        in_memRead,
    input  logic        in_memWrite,
    input  logic        in_regWrite,
    input  logic        in_halt,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    input  logic        mem_err,
    output logic        stall_out,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic        wb_halt,
    output logic        err,
    output logic [2:0]  wb_writeBackOp,
    output logic [2:0]  wb_writeReg,
    output logic [15:0] wb_incPC,
    output logic [15:0] wb_dReadData,
    output logic [15:0] wb_aluResult,
    output logic [15:0] wb_inst7_0Ext,
    output logic [15:0] wb_aluControl
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_regWrite_q, wb_regWrite_d;
    logic        wb_halt_q, wb_halt_d;
    logic        err_q, err_d;
    logic [2:0]  wb_writeBackOp_q, wb_writeBackOp_d;
    logic [2:0]  wb_writeReg_q, wb_writeReg_d;
    logic [15:0] wb_incPC_q, wb_incPC_d;
    logic [15:0] wb_dReadData_q, wb_dReadData_d;
    logic [15:0] wb_aluResult_q, wb_aluResult_d;
    logic [15:0] wb_inst7_0Ext_q, wb_inst7_0Ext_d;
    logic [15:0] wb_aluControl_q, wb_aluControl_d;

    logic mem_op, illegal, issue, stall, load, kill_wr, err_set, take_rdata;

    assign mem_op  = in_valid & (in_memRead | in_memWrite);
    assign illegal = in_aluResult[0] | (in_memRead & in_memWrite);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        issue      = 1'b0;
        stall      = 1'b0;
        load       = 1'b0;
        kill_wr    = 1'b0;
        err_set    = 1'b0;
        take_rdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !illegal) begin
                    stall = 1'b1;
                    if (!mem_stall) begin
                        issue   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = 7'd0;
                    end
                end else begin
                    // Unaligned or contradictory accesses complete at once, flagged as errors
                    load    = 1'b1;
                    kill_wr = mem_op;
                    err_set = mem_op;
                end
            end
            WAIT: begin
                if (mem_done) begin
                    load       = 1'b1;
                    take_rdata = in_memRead;
                    err_set    = mem_err;
                    state_d    = IDLE;
                    cnt_d      = 7'd0;
                end else if (cnt_q == CNT_LAST) begin
                    load    = 1'b1;
                    kill_wr = 1'b1;
                    err_set = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 7'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 7'd0;
            end
        endcase
    end

    // Payload fields hold during a bubble; only the qualifying flags are forced low
    always_comb begin
        wb_valid_d       = 1'b0;
        wb_regWrite_d    = 1'b0;
        wb_halt_d        = 1'b0;
        err_d            = 1'b0;
        wb_writeBackOp_d = wb_writeBackOp_q;
        wb_writeReg_d    = wb_writeReg_q;
        wb_incPC_d       = wb_incPC_q;
        wb_dReadData_d   = wb_dReadData_q;
        wb_aluResult_d   = wb_aluResult_q;
        wb_inst7_0Ext_d  = wb_inst7_0Ext_q;
        wb_aluControl_d  = wb_aluControl_q;
        if (load) begin
            wb_valid_d       = in_valid;
            wb_regWrite_d    = in_regWrite & ~kill_wr;
            wb_halt_d        = in_halt;
            err_d            = err_set;
            wb_writeBackOp_d = in_writeBackOp;
            wb_writeReg_d    = in_writeReg;
            wb_incPC_d       = in_incPC;
            wb_dReadData_d   = take_rdata ? mem_rdata : 16'h0000;
            wb_aluResult_d   = in_aluResult;
            wb_inst7_0Ext_d  = in_inst7_0Ext;
            wb_aluControl_d  = in_aluControl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= 7'd0;
            wb_valid_q       <= 1'b0;
            wb_regWrite_q    <= 1'b0;
            wb_halt_q        <= 1'b0;
            err_q            <= 1'b0;
            wb_writeBackOp_q <= 3'd0;
            wb_writeReg_q    <= 3'd0;
            wb_incPC_q       <= 16'h0000;
            wb_dReadData_q   <= 16'h0000;
            wb_aluResult_q   <= 16'h0000;
            wb_inst7_0Ext_q  <= 16'h0000;
            wb_aluControl_q  <= 16'h0000;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            wb_valid_q       <= wb_valid_d;
            wb_regWrite_q    <= wb_regWrite_d;
            wb_halt_q        <= wb_halt_d;
            err_q            <= err_d;
            wb_writeBackOp_q <= wb_writeBackOp_d;
            wb_writeReg_q    <= wb_writeReg_d;
            wb_incPC_q       <= wb_incPC_d;
            wb_dReadData_q   <= wb_dReadData_d;
            wb_aluResult_q   <= wb_aluResult_d;
            wb_inst7_0Ext_q  <= wb_inst7_0Ext_d;
            wb_aluControl_q  <= wb_aluControl_d;
        end
    end

    assign mem_rd    = rst_n & issue & in_memRead;
    assign mem_wr    = rst_n & issue & in_memWrite;
    assign mem_addr  = (rst_n & issue) ? in_aluResult : 16'h0000;
    assign mem_wdata = (rst_n & issue) ? in_writeData : 16'h0000;
    assign stall_out = rst_n & stall;

    assign wb_valid       = wb_valid_q;
    assign wb_regWrite    = wb_regWrite_q;
    assign wb_halt        = wb_halt_q;
    assign err            = err_q;
    assign wb_writeBackOp = wb_writeBackOp_q;
    assign wb_writeReg    = wb_writeReg_q;
    assign wb_incPC       = wb_incPC_q;
    assign wb_dReadData   = wb_dReadData_q;
    assign wb_aluResult   = wb_aluResult_q;
    assign wb_inst7_0Ext  = wb_inst7_0Ext_q;
    assign wb_aluControl  = wb_aluControl_q;

endmodule
